int_ds_dispatch_queue: RTL and testbench
========================================

// Module: int_ds_dispatch_queue
// PURPOSE
//  Dispatch-side producer for the integer reservation station: buffers renamed uop bundles and
//  presents them on ds_rs_itf.ds with all-or-nothing handshake. Snoops the CDB so source-ready
//  bits are never stale when an entry lands in the RS. Sits between rename and int RS.
// PARAMETERS
//  DQ_DEPTH     4         bundles buffered; power of two, >=2
//  DQ_IDX       $clog2(DQ_DEPTH)  pointer width (derived)
//  ID_WIDTH     cpu_params  uops per bundle
//  CDB_WIDTH    cpu_params  wakeup broadcast ports
// PORTS
//  clk          in   1              clock
//  rst          in   1              reset: synchronous, active-high
//  flush        in   1              backend flush; drop all buffered bundles
//  rn_valid     in   ID_WIDTH       per-slot valid of incoming bundle
//  rn_uop       in   ID_WIDTH x uop_t  renamed uops (rob_id, rs1/rs2_phy+valid, rd_phy/arch, sel, imm, opcode)
//  rn_ready     out  1              queue accepts a bundle this cycle
//  to_rs        if   ds_rs_itf.ds   valid[ID_WIDTH], uop[ID_WIDTH] out; ready in
//  cdb          if   cdb_itf.rs [CDB_WIDTH]  snoop: valid, rd_phy
// BEHAVIOUR
//  - Storage: DQ_DEPTH bundles; bundle = ID_WIDTH uops + per-slot valid mask; circular, head/tail
//    DQ_IDX bits, count DQ_IDX+1 bits. Pointers wrap modulo DQ_DEPTH.
//  - Reset/flush: head=tail=count=0, all slot valids 0 -> to_rs.valid='0, rn_ready=1 next cycle.
//    rst wins over flush; flush wins over same-cycle enqueue/dequeue (both discarded).
//  - Enqueue: fire when |rn_valid && rn_ready; writes rn_valid mask + uops at tail, tail++.
//    Bundle with rn_valid=='0 is never written. rn_ready = (count != DQ_DEPTH); registered
//    state only, no combinational path from to_rs.ready. Full + simultaneous dequeue -> still 0.
//  - Dequeue: to_rs.valid[w] = (count!=0) & head.valid[w]; to_rs.uop = head uops.
//    Fire when count!=0 && to_rs.ready: whole bundle leaves in one cycle, head++.
//    RS ready is all-or-nothing; no partial bundle issue. Min latency rn->to_rs: 1 cycle.
//  - Same-cycle enq+deq: count unchanged; at count==1 the new bundle becomes head next cycle.
//  - Wakeup (stored): each cycle, for every stored valid slot and every cdb[k] with valid,
//    rs1_valid |= (rs1_phy==cdb[k].rd_phy); same for rs2. Bits never clear.
//  - Wakeup (enqueue): incoming uops snooped against same-cycle CDB before being written.
//  - Wakeup (output): to_rs.uop[w].rsN_valid = stored bit | same-cycle CDB match, so a broadcast
//    in the transfer cycle is not lost by the RS (which only snoops entries it already holds).
//  - rd_phy==0 broadcasts match like any tag; rename never allocates p0 as a pending source.
//  - All outputs after reset: rn_ready=1, to_rs.valid='0, to_rs.uop don't-care ('x allowed).
// STRUCTURE
//  - uop_types: reuse uop_t; add dq_bundle_t {logic valid[ID_WIDTH]; uop_t uop[ID_WIDTH];}.
//  - cpu_params: add DQ_DEPTH.
//  - Sub-module cdb_wakeup_match: (rs_phy, cdb[]) -> hit; instantiated per source per slot for
//    stored, enqueue and output paths. Queue storage/pointers stay in this module.
// TESTING
//  1. rst, then rn_valid=2'b11 cycle 1, to_rs.ready=1 -> to_rs.valid=2'b11 cycle 2, rn_ready=1 throughout.
//  2. to_rs.ready=0, push 4 bundles -> rn_ready=0 after 4th; 5th held; ready=1 -> head pops, rn_ready=1 next cycle, order preserved (rob_id 0..7).
//  3. Stored uop rs1_phy=17 rs1_valid=0, cdb[0] valid rd_phy=17 -> rs1_valid=1 on output next cycle and stays.
//  4. Head uop rs2_phy=9 pending, cdb[1] rd_phy=9 in same cycle as to_rs.ready=1 -> transferred uop shows rs2_valid=1.
//  5. Enqueue uop rs1_phy=5 while cdb rd_phy=5 -> stored with rs1_valid=1.
//  6. count=3, flush with simultaneous enq+deq -> next cycle to_rs.valid='0, rn_ready=1, count=0.

Source files
------------

// File: rtl/int_ds_dispatch_queue_pkg.sv
// rtl/int_ds_dispatch_queue_pkg.sv - shared parameters and types for the int dispatch queue
package int_ds_dispatch_queue_pkg;

  localparam int ID_WIDTH  = 2;
  localparam int CDB_WIDTH = 2;
  localparam int DQ_DEPTH  = 4;
  localparam int DQ_IDX    = $clog2(DQ_DEPTH);
  localparam int PHY_W     = 6;
  localparam int ROB_W     = 6;

  typedef struct packed {
    logic [ROB_W-1:0] rob_id;
    logic [PHY_W-1:0] rs1_phy;
    logic             rs1_valid;
    logic [PHY_W-1:0] rs2_phy;
    logic             rs2_valid;
    logic [PHY_W-1:0] rd_phy;
    logic [4:0]       rd_arch;
    logic [1:0]       sel;
    logic [31:0]      imm;
    logic [6:0]       opcode;
  } uop_t;

  // One dispatch bundle: per-slot valid mask plus the uops themselves
  typedef struct packed {
    logic [ID_WIDTH-1:0]       valid;
    uop_t [ID_WIDTH-1:0]       uop;
  } dq_bundle_t;

endpackage

// File: rtl/int_ds_dispatch_queue_match.sv
// rtl/int_ds_dispatch_queue_match.sv - CDB tag comparator for one source operand
module cdb_wakeup_match
  import int_ds_dispatch_queue_pkg::*;
(
  input  logic [PHY_W-1:0]                 rs_phy,
  input  logic [CDB_WIDTH-1:0]             cdb_valid,
  input  logic [CDB_WIDTH-1:0][PHY_W-1:0]  cdb_rd_phy,
  output logic                             hit
);

  // Any valid broadcast carrying this tag wakes the source; p0 is not special
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (cdb_valid[k] && (cdb_rd_phy[k] == rs_phy)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/int_ds_dispatch_queue.sv
// rtl/int_ds_dispatch_queue.sv - bundle FIFO between rename and the int RS with CDB snooping
module int_ds_dispatch_queue
  import int_ds_dispatch_queue_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [ID_WIDTH-1:0]              rn_valid,
  input  uop_t [ID_WIDTH-1:0]              rn_uop,
  output logic                             rn_ready,
  output logic [ID_WIDTH-1:0]              to_rs_valid,
  output uop_t [ID_WIDTH-1:0]              to_rs_uop,
  input  logic                             to_rs_ready,
  input  logic [CDB_WIDTH-1:0]             cdb_valid,
  input  logic [CDB_WIDTH-1:0][PHY_W-1:0]  cdb_rd_phy
);

  localparam logic [DQ_IDX:0] DQ_FULL = DQ_DEPTH[DQ_IDX:0];

  dq_bundle_t        mem_q [DQ_DEPTH];
  dq_bundle_t        mem_d [DQ_DEPTH];
  logic [DQ_IDX-1:0] head_q, head_d, tail_q, tail_d;
  logic [DQ_IDX:0]   count_q, count_d;

  logic [DQ_DEPTH-1:0][ID_WIDTH-1:0] st_hit1, st_hit2;
  logic [ID_WIDTH-1:0] enq_hit1, enq_hit2, out_hit1, out_hit2;
  logic enq_fire, deq_fire;
  dq_bundle_t head_b;

  assign head_b   = mem_q[head_q];
  assign rn_ready = (count_q != DQ_FULL);
  assign enq_fire = (|rn_valid) && rn_ready;
  assign deq_fire = (count_q != '0) && to_rs_ready;

  for (genvar e = 0; e < DQ_DEPTH; e++) begin : g_st
    for (genvar w = 0; w < ID_WIDTH; w++) begin : g_slot
      cdb_wakeup_match u_m1 (.rs_phy(mem_q[e].uop[w].rs1_phy), .cdb_valid(cdb_valid),
                             .cdb_rd_phy(cdb_rd_phy), .hit(st_hit1[e][w]));
      cdb_wakeup_match u_m2 (.rs_phy(mem_q[e].uop[w].rs2_phy), .cdb_valid(cdb_valid),
                             .cdb_rd_phy(cdb_rd_phy), .hit(st_hit2[e][w]));
    end
  end

  for (genvar w = 0; w < ID_WIDTH; w++) begin : g_io
    cdb_wakeup_match u_e1 (.rs_phy(rn_uop[w].rs1_phy), .cdb_valid(cdb_valid),
                           .cdb_rd_phy(cdb_rd_phy), .hit(enq_hit1[w]));
    cdb_wakeup_match u_e2 (.rs_phy(rn_uop[w].rs2_phy), .cdb_valid(cdb_valid),
                           .cdb_rd_phy(cdb_rd_phy), .hit(enq_hit2[w]));
    cdb_wakeup_match u_o1 (.rs_phy(head_b.uop[w].rs1_phy), .cdb_valid(cdb_valid),
                           .cdb_rd_phy(cdb_rd_phy), .hit(out_hit1[w]));
    cdb_wakeup_match u_o2 (.rs_phy(head_b.uop[w].rs2_phy), .cdb_valid(cdb_valid),
                           .cdb_rd_phy(cdb_rd_phy), .hit(out_hit2[w]));
  end

  // Head bundle goes out with same-cycle wakeups folded in so the RS never misses them
  always_comb begin
    to_rs_valid = '0;
    to_rs_uop   = head_b.uop;
    for (int w = 0; w < ID_WIDTH; w++) begin
      to_rs_valid[w]         = (count_q != '0) && head_b.valid[w];
      to_rs_uop[w].rs1_valid = head_b.uop[w].rs1_valid | out_hit1[w];
      to_rs_uop[w].rs2_valid = head_b.uop[w].rs2_valid | out_hit2[w];
    end
  end

  // Next state: stored wakeup, then enqueue/dequeue, with flush overriding both
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int e = 0; e < DQ_DEPTH; e++) begin
      for (int w = 0; w < ID_WIDTH; w++) begin
        if (mem_q[e].valid[w]) begin
          mem_d[e].uop[w].rs1_valid = mem_q[e].uop[w].rs1_valid | st_hit1[e][w];
          mem_d[e].uop[w].rs2_valid = mem_q[e].uop[w].rs2_valid | st_hit2[e][w];
        end
      end
    end
    if (flush) begin
      for (int e = 0; e < DQ_DEPTH; e++) mem_d[e].valid = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) begin
        mem_d[tail_q].valid = rn_valid;
        for (int w = 0; w < ID_WIDTH; w++) begin
          mem_d[tail_q].uop[w]           = rn_uop[w];
          mem_d[tail_q].uop[w].rs1_valid = rn_uop[w].rs1_valid | enq_hit1[w];
          mem_d[tail_q].uop[w].rs2_valid = rn_uop[w].rs2_valid | enq_hit2[w];
        end
        tail_d = tail_q + 1'b1;
      end
      if (deq_fire) head_d = head_q + 1'b1;
      if (enq_fire && !deq_fire) count_d = count_q + 1'b1;
      else if (!enq_fire && deq_fire) count_d = count_q - 1'b1;
    end
  end

  // State registers; reset clears pointers and every slot valid
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_int_ds_dispatch_queue.sv
// tb/tb_int_ds_dispatch_queue.sv - randomized bench against a queue-based reference model
module tb_int_ds_dispatch_queue;
  import int_ds_dispatch_queue_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst, flush, rn_ready, to_rs_ready;
  logic [ID_WIDTH-1:0]             rn_valid, to_rs_valid;
  uop_t [ID_WIDTH-1:0]             rn_uop, to_rs_uop;
  logic [CDB_WIDTH-1:0]            cdb_valid;
  logic [CDB_WIDTH-1:0][PHY_W-1:0] cdb_rd_phy;

  int n_checks = 0;
  int n_pass   = 0;
  dq_bundle_t model_q[$];
  int rob_ctr = 0;

  always #5 clk = ~clk;

  int_ds_dispatch_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rn_valid(rn_valid), .rn_uop(rn_uop), .rn_ready(rn_ready),
    .to_rs_valid(to_rs_valid), .to_rs_uop(to_rs_uop), .to_rs_ready(to_rs_ready),
    .cdb_valid(cdb_valid), .cdb_rd_phy(cdb_rd_phy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic cdb_hit(input logic [PHY_W-1:0] phy);
    for (int k = 0; k < CDB_WIDTH; k++)
      if (cdb_valid[k] && cdb_rd_phy[k] == phy) return 1'b1;
    return 1'b0;
  endfunction

  function automatic uop_t woken(input uop_t u);
    uop_t r = u;
    if (cdb_hit(u.rs1_phy)) r.rs1_valid = 1'b1;
    if (cdb_hit(u.rs2_phy)) r.rs2_valid = 1'b1;
    return r;
  endfunction

  task automatic drive_random(input int cyc);
    logic [95:0] r;
    int ready_pct;
    ready_pct = ((cyc / 50) % 2 == 0) ? 85 : 15;
    rst         = (cyc < 2) || ($urandom_range(0, 299) == 0);
    flush       = ($urandom_range(0, 39) == 0);
    to_rs_ready = ($urandom_range(0, 99) < ready_pct);
    rn_valid    = ($urandom_range(0, 3) == 0) ? '0 : ID_WIDTH'($urandom());
    for (int w = 0; w < ID_WIDTH; w++) begin
      r = {$urandom(), $urandom(), $urandom()};
      rn_uop[w]         = r[$bits(uop_t)-1:0];
      rn_uop[w].rob_id  = ROB_W'(rob_ctr + w);
      rn_uop[w].rs1_phy = PHY_W'($urandom_range(0, 15));
      rn_uop[w].rs2_phy = PHY_W'($urandom_range(0, 15));
    end
    for (int k = 0; k < CDB_WIDTH; k++) begin
      cdb_valid[k]  = ($urandom_range(0, 2) == 0);
      cdb_rd_phy[k] = PHY_W'($urandom_range(0, 15));
    end
  endtask

  task automatic check_outputs();
    logic [ID_WIDTH-1:0] exp_valid;
    uop_t exp_u;
    check_eq("rn_ready", 128'(rn_ready), 128'(model_q.size() != DQ_DEPTH));
    exp_valid = (model_q.size() > 0) ? model_q[0].valid : '0;
    check_eq("to_rs_valid", 128'(to_rs_valid), 128'(exp_valid));
    for (int w = 0; w < ID_WIDTH; w++) begin
      if (exp_valid[w]) begin
        exp_u = woken(model_q[0].uop[w]);
        check_eq($sformatf("to_rs_uop[%0d]", w), 128'(to_rs_uop[w]), 128'(exp_u));
      end
    end
  endtask

  task automatic update_model();
    bit enq, deq;
    dq_bundle_t b;
    if (rst || flush) begin
      model_q.delete();
      return;
    end
    enq = (rn_valid != '0) && (model_q.size() != DQ_DEPTH);
    deq = (model_q.size() > 0) && to_rs_ready;
    foreach (model_q[i])
      for (int w = 0; w < ID_WIDTH; w++)
        if (model_q[i].valid[w]) model_q[i].uop[w] = woken(model_q[i].uop[w]);
    if (deq) void'(model_q.pop_front());
    if (enq) begin
      b.valid = rn_valid;
      for (int w = 0; w < ID_WIDTH; w++) b.uop[w] = woken(rn_uop[w]);
      model_q.push_back(b);
      rob_ctr += ID_WIDTH;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; to_rs_ready = 1'b0; rn_valid = '0; rn_uop = '0;
    cdb_valid = '0; cdb_rd_phy = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drive_random(cyc);
      #1;
      if (cyc >= 2) check_outputs();
      @(posedge clk);
      update_model();
    end
    // directed: post-reset state and one-cycle rename-to-dispatch latency
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; rn_valid = '0; cdb_valid = '0; to_rs_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_rn_ready", 128'(rn_ready), 128'(1'b1));
    check_eq("reset_valid", 128'(to_rs_valid), 128'(0));
    rn_valid = '1;
    @(negedge clk);
    rn_valid = '0;
    #1;
    check_eq("lat1_valid", 128'(to_rs_valid), 128'({ID_WIDTH{1'b1}}));
    check_eq("lat1_rn_ready", 128'(rn_ready), 128'(1'b1));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
